// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that time-shares one combinational single-precision adder among NUM_REQ
// requesters, with one operation in flight and a shared backpressured response channel.

// Combinational IEEE-754 single-precision adder: round-to-nearest-even, subnormals flushed to zero.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        overflow,
  output logic        underflow
);
  logic              a_big;
  logic [31:0]       x;
  logic [31:0]       y;
  logic [7:0]        ex;
  logic [7:0]        ey;
  logic [7:0]        diff;
  logic [26:0]       mx;
  logic [26:0]       my;
  logic [26:0]       my_sh;
  logic [26:0]       my_al;
  logic              sticky;
  logic [27:0]       raw;
  logic [26:0]       norm;
  logic [4:0]        lz;
  logic              found;
  logic signed [9:0] exp_w;
  logic              rnd_up;
  logic [24:0]       rounded;
  logic              unused_hidden;

  always_comb begin
    sum       = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    my_sh     = '0;
    sticky    = 1'b0;
    my_al     = '0;
    lz        = '0;
    found     = 1'b0;
    norm      = '0;

    // x carries the larger magnitude so the result takes its sign and exponent
    a_big = (a[30:0] >= b[30:0]);
    x     = a_big ? a : b;
    y     = a_big ? b : a;
    ex    = x[30:23];
    ey    = y[30:23];
    mx    = (ex == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my    = (ey == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    diff  = ex - ey;

    if (diff >= 8'd27) begin
      my_al = {26'd0, |my};
    end else begin
      my_sh  = my >> diff;
      sticky = |(my & ~({27{1'b1}} << diff));
      my_al  = {my_sh[26:1], my_sh[0] | sticky};
    end

    raw = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my_al})
                           : ({1'b0, mx} - {1'b0, my_al});

    for (int i = 26; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end

    exp_w = $signed({2'b00, ex});
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_w = exp_w + 10'sd1;
    end else begin
      // left shifts only follow near-total cancellation, where no sticky bits were lost
      norm  = raw[26:0] << lz;
      exp_w = exp_w - $signed({5'd0, lz});
    end

    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[26:3]} + 25'(rnd_up);
    if (rounded[24]) begin
      rounded = rounded >> 1;
      exp_w   = exp_w + 10'sd1;
    end

    if (ex == 8'hFF) begin
      sum = (ey == 8'hFF && x[31] != y[31]) ? 32'h7FC0_0000 : x;
    end else if (mx == 27'd0) begin
      sum = {a[31] & b[31], 31'd0};
    end else if (raw == 28'd0) begin
      sum = '0;
    end else if (exp_w >= 10'sd255) begin
      overflow = 1'b1;
      sum      = {x[31], 8'hFF, 23'd0};
    end else if (exp_w <= 10'sd0) begin
      underflow = 1'b1;
      sum       = {x[31], 31'd0};
    end else begin
      sum = {x[31], exp_w[7:0], rounded[22:0]};
    end
  end

  assign unused_hidden = rounded[23];
endmodule

module fp_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_overflow,
  output logic                  rsp_underflow,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_count,
  output logic [CNT_W-1:0]      exc_count
);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [ID_W-1:0]    op_id;
  logic [ID_W-1:0]    op_id_d;
  logic [DW-1:0]      op_a;
  logic [DW-1:0]      op_a_d;
  logic [DW-1:0]      op_b;
  logic [DW-1:0]      op_b_d;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_oh;
  logic [DW-1:0]      grant_a;
  logic [DW-1:0]      grant_b;
  logic               rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_d;
  logic [DW-1:0]      rsp_sum_d;
  logic               rsp_overflow_d;
  logic               rsp_underflow_d;
  logic [CNT_W-1:0]   done_count_d;
  logic [CNT_W-1:0]   exc_count_d;
  logic [DW-1:0]      add_sum;
  logic               add_overflow;
  logic               add_underflow;

  fp_adder u_fp_adder (
    .a         (op_a),
    .b         (op_b),
    .sum       (add_sum),
    .overflow  (add_overflow),
    .underflow (add_underflow)
  );

  // Rotating-priority search: indices >= rr_ptr first, then wrap around below it
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    grant_a     = '0;
    grant_b     = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!grant_found && req_valid[i] &&
            ((pass == 0) ? (ID_W'(i) >= rr_ptr) : (ID_W'(i) < rr_ptr))) begin
          grant_found = 1'b1;
          grant_id    = ID_W'(i);
          grant_oh[i] = 1'b1;
          grant_a     = req_a[DW*i +: DW];
          grant_b     = req_b[DW*i +: DW];
        end
      end
    end
  end

  assign req_ready = (state == IDLE && !rst) ? grant_oh : '0;

  always_comb begin
    state_d         = state;
    rr_ptr_d        = rr_ptr;
    op_id_d         = op_id;
    op_a_d          = op_a;
    op_b_d          = op_b;
    rsp_valid_d     = rsp_valid;
    rsp_id_d        = rsp_id;
    rsp_sum_d       = rsp_sum;
    rsp_overflow_d  = rsp_overflow;
    rsp_underflow_d = rsp_underflow;
    done_count_d    = done_count;
    exc_count_d     = exc_count;
    case (state)
      IDLE: begin
        if (grant_found) begin
          op_id_d  = grant_id;
          op_a_d   = grant_a;
          op_b_d   = grant_b;
          rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d     = 1'b1;
        rsp_id_d        = op_id;
        rsp_sum_d       = add_sum;
        rsp_overflow_d  = add_overflow;
        rsp_underflow_d = add_underflow;
        state_d         = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count + CNT_W'(1);
          if (rsp_overflow || rsp_underflow) begin
            exc_count_d = exc_count + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_id         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_sum       <= '0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      busy          <= 1'b0;
      done_count    <= '0;
      exc_count     <= '0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      op_id         <= op_id_d;
      op_a          <= op_a_d;
      op_b          <= op_b_d;
      rsp_valid     <= rsp_valid_d;
      rsp_id        <= rsp_id_d;
      rsp_sum       <= rsp_sum_d;
      rsp_overflow  <= rsp_overflow_d;
      rsp_underflow <= rsp_underflow_d;
      busy          <= (state_d != IDLE);
      done_count    <= done_count_d;
      exc_count     <= exc_count_d;
    end
  end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: reset, single op, signs, round-robin, backpressure,
// exception counting and reset in the middle of an operation.
module tb_fp_adder_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_overflow;
  logic                  rsp_underflow;
  logic                  busy;
  logic [CNT_W-1:0]      done_count;
  logic [CNT_W-1:0]      exc_count;

  int total = 0;
  int bad   = 0;
  int exp_done = 0;
  int exp_exc  = 0;

  fp_adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_sum       (rsp_sum),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow),
    .busy          (busy),
    .done_count    (done_count),
    .exc_count     (exc_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  // Handshake requester i on an idle arbiter and advance into RESP with rsp_ready low
  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b);
    drive(i, a, b);
    tick();
    req_valid[i] = 1'b0;
    tick();
  endtask

  task automatic consume(input bit exc);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_done++;
    if (exc) exp_exc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    tick();
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rsp_sum !== 32'h0 || rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_data got=%h/%0d want=0/0", rsp_sum, rsp_id); end
    total++; if (done_count !== 16'd0 || exc_count !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", done_count, exc_count); end
    req_valid = '0;
    rst = 1'b0;
    exp_done = 0;
    exp_exc  = 0;
    tick();
  endtask

  task automatic test_single_op();
    drive(0, 32'h3F80_0000, 32'h3F00_0000);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_req_ready got=%b want=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec got busy=%b valid=%b want 1/0", busy, rsp_valid); end
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d want=0", rsp_id); end
    total++; if (rsp_sum !== 32'h3FC0_0000) begin bad++; $display("FAIL single_sum got=%h want=3fc00000", rsp_sum); end
    total++; if (rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0) begin bad++; $display("FAIL single_flags got=%b%b want=00", rsp_overflow, rsp_underflow); end
    consume(1'b0);
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_release got valid=%b busy=%b want 0/0", rsp_valid, busy); end
    total++; if (done_count !== 16'(exp_done)) begin bad++; $display("FAIL single_done got=%0d want=%0d", done_count, exp_done); end
  endtask

  task automatic test_sign();
    run_op(2, 32'hBE80_0000, 32'hBE00_0000);
    total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL sign_neg_id got=%0d want=2", rsp_id); end
    total++; if (rsp_sum !== 32'hBEC0_0000) begin bad++; $display("FAIL sign_neg_sum got=%h want=bec00000", rsp_sum); end
    consume(1'b0);
    run_op(2, 32'h3F80_0000, 32'hBF00_0000);
    total++; if (rsp_sum !== 32'h3F00_0000) begin bad++; $display("FAIL sign_mixed_sum got=%h want=3f000000", rsp_sum); end
    consume(1'b0);
    total++; if (done_count !== 16'(exp_done)) begin bad++; $display("FAIL sign_done got=%0d want=%0d", done_count, exp_done); end
  endtask

  task automatic test_backpressure();
    drive(3, 32'h3F80_0000, 32'h3F80_0000);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant3 got=%b want=1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    drive(1, 32'h4000_0000, 32'h4000_0000);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_exec_ready got=%b want=0000", req_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h4000_0000 || rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got valid=%b sum=%h id=%0d ready=%b want 1/40000000/3/0000",
                 c, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      tick();
    end
    consume(1'b0);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/0010", rsp_valid, req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    total++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h4080_0000) begin bad++; $display("FAIL bp_second got id=%0d sum=%h want 1/40800000", rsp_id, rsp_sum); end
    consume(1'b0);
    total++; if (done_count !== 16'(exp_done)) begin bad++; $display("FAIL bp_done got=%0d want=%0d", done_count, exp_done); end
  endtask

  task automatic test_exception();
    run_op(0, 32'h7F5F_FFFE, 32'h7F5F_FFFF);
    total++; if (rsp_overflow !== 1'b1 || rsp_underflow !== 1'b0) begin bad++; $display("FAIL exc_flags got=%b%b want=10", rsp_overflow, rsp_underflow); end
    consume(1'b1);
    total++; if (exc_count !== 16'(exp_exc)) begin bad++; $display("FAIL exc_count_ovf got=%0d want=%0d", exc_count, exp_exc); end
    run_op(0, 32'hC093_3333, 32'h4093_3333);
    total++; if (rsp_sum !== 32'h0 || rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0) begin bad++; $display("FAIL exc_cancel got sum=%h flags=%b%b want 0/00", rsp_sum, rsp_overflow, rsp_underflow); end
    consume(1'b0);
    total++; if (exc_count !== 16'(exp_exc) || done_count !== 16'(exp_done)) begin bad++; $display("FAIL exc_count_cancel got=%0d/%0d want=%0d/%0d", exc_count, done_count, exp_exc, exp_done); end
  endtask

  task automatic test_round_robin();
    int g[5];
    int gc[5];
    int ng;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_done = 0;
    exp_exc  = 0;
    for (int i = 0; i < 4; i++) drive(i, 32'h3F80_0000, 32'h3F80_0000);
    rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) g[ng] = i;
        gc[ng] = c;
        ng++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    tick();
    tick();
    rsp_ready = 1'b0;
    exp_done = 5;
    total++; if (ng !== 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", ng); end
    for (int k = 0; k < ng; k++) begin
      total++; if (g[k] !== k % 4) begin bad++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, g[k], k % 4); end
      if (k > 0) begin
        total++; if (gc[k] - gc[k-1] !== 3) begin bad++; $display("FAIL rr_spacing k=%0d got=%0d want=3", k, gc[k] - gc[k-1]); end
      end
    end
    total++; if (done_count !== 16'(exp_done) || busy !== 1'b0) begin bad++; $display("FAIL rr_done got=%0d busy=%b want=%0d/0", done_count, busy, exp_done); end
  endtask

  task automatic test_reset_mid_op();
    drive(1, 32'h3F80_0000, 32'h3F00_0000);
    tick();
    req_valid = '0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_exec got busy=%b want=1", busy); end
    rst = 1'b1;
    tick();
    req_valid = '1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_state got valid=%b busy=%b want 0/0", rsp_valid, busy); end
    total++; if (done_count !== 16'd0 || exc_count !== 16'd0) begin bad++; $display("FAIL midrst_counts got=%0d/%0d want=0/0", done_count, exc_count); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_rrptr got=%b want=0001", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (rsp_valid !== 1'b0 || done_count !== 16'd0) begin bad++; $display("FAIL midrst_stale cyc=%0d got valid=%b done=%0d want 0/0", c, rsp_valid, done_count); end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_sign();
    test_backpressure();
    test_exception();
    test_round_robin();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
